fixed_point_multiplier: RTL and testbench

// - Sequential unsigned fixed-point multiplier. It is the companion to the team's fixed-point divider.
// - It uses the same start/busy/valid handshake and the same operand format, so the two blocks are interchangeable to the controller.
// - It computes Q_out = A_in * B_in in Q(W-F).F format, using one shift-add step per clock.
// - Overflowing results saturate.

---
 rtl/fixed_point_multiplier.sv | 91 +++++++++
 tb/tb_fixed_point_multiplier.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fixed_point_multiplier.sv
// Sequential unsigned Q(W-F).F multiplier: one shift-add step per clock, saturating output.
// Same start/busy/valid handshake and operand format as the fixed-point divider.
module fixed_point_multiplier #(
    parameter int W = 10,
    parameter int F = 6
) (
    input  logic         clk,
    input  logic         sclr,
    input  logic         start,
    input  logic [W-1:0] A_in,
    input  logic [W-1:0] B_in,
    output logic [W-1:0] Q_out,
    output logic         busy,
    output logic         valid,
    output logic         ovf
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state;
    logic [2*W-1:0]   a_r;
    logic [W-1:0]     b_r;
    logic [2*W-1:0]   acc;
    logic [CNT_W-1:0] cnt;

    logic [2*W-1:0]   p;
    logic [2*W-1:0]   p_shift;

    // The final step's add is folded in here so the result registers directly on the last edge.
    // NOTE: every always_comb output gets a value on every path; a missing assignment infers a latch.
    always_comb begin
        p       = acc + (b_r[0] ? a_r : '0);
        p_shift = p >> F;
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            Q_out <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= {{W{1'b0}}, A_in};
                        b_r   <= B_in;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= p;
                    a_r <= a_r << 1;
                    b_r <= b_r >> 1;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // Any set bit above the integer field means the product does not fit.
                        if (|p_shift[2*W-1:W]) begin
                            Q_out <= {W{1'b1}};
                            ovf   <= 1'b1;
                        end else begin
                            Q_out <= p_shift[W-1:0];
                            ovf   <= 1'b0;
                        end
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Directed bench for fixed_point_multiplier: hand-computed products, handshake, abort.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_fixed_point_multiplier;

    localparam int W = 10;
    localparam int F = 6;

    logic         clk = 1'b0;
    logic         sclr;
    logic         start;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic [W-1:0] Q_out;
    logic         busy;
    logic         valid;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    fixed_point_multiplier #(.W(W), .F(F)) dut (
        .clk   (clk),
        .sclr  (sclr),
        .start (start),
        .A_in  (A_in),
        .B_in  (B_in),
        .Q_out (Q_out),
        .busy  (busy),
        .valid (valid),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and check busy for W cycles, the valid pulse, and its drop.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_q, input logic exp_ovf);
        A_in  = a;
        B_in  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check($sformatf("%s_busy%0d", tag, i), {31'b0, busy}, 32'd1);
            check($sformatf("%s_novalid%0d", tag, i), {31'b0, valid}, 32'd0);
            step();
        end
        check({tag, "_valid"}, {31'b0, valid}, 32'd1);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        check({tag, "_q"}, {22'b0, Q_out}, {22'b0, exp_q});
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
        step();
        check({tag, "_valid_drop"}, {31'b0, valid}, 32'd0);
        check({tag, "_q_hold"}, {22'b0, Q_out}, {22'b0, exp_q});
    endtask

    initial begin
        sclr  = 1'b1;
        start = 1'b0;
        A_in  = '0;
        B_in  = '0;
        step();
        step();
        check("rst_q", {22'b0, Q_out}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        sclr = 1'b0;
        step();

        // Basic products and saturation/truncation boundaries.
        do_op("half",    10'h040, 10'h020, 10'h020, 1'b0);
        do_op("two_x3",  10'h080, 10'h0C0, 10'h180, 1'b0);
        do_op("max_x1",  10'h3FF, 10'h040, 10'h3FF, 1'b0);
        do_op("sat",     10'h200, 10'h080, 10'h3FF, 1'b1);
        do_op("tiny",    10'h001, 10'h001, 10'h000, 1'b0);
        do_op("zero",    10'h000, 10'h3FF, 10'h000, 1'b0);

        // Start pulsed mid-operation with other operands must be ignored.
        A_in  = 10'h040;
        B_in  = 10'h020;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        A_in  = 10'h200;
        B_in  = 10'h080;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 3; i < W; i++) step();
        check("ign_valid", {31'b0, valid}, 32'd1);
        check("ign_q", {22'b0, Q_out}, 32'h020);
        check("ign_ovf", {31'b0, ovf}, 32'd0);
        step();
        check("ign_no_restart", {31'b0, busy}, 32'd0);
        check("ign_valid_drop", {31'b0, valid}, 32'd0);

        // Start held for 30 edges: results at E10, E21, E32.
        A_in  = 10'h080;
        B_in  = 10'h0C0;
        start = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            logic done;
            step();
            if (k == 29) start = 1'b0;
            done = (k == 10) || (k == 21) || (k == 32);
            check($sformatf("b2b_valid%0d", k), {31'b0, valid}, {31'b0, done});
            check($sformatf("b2b_busy%0d", k), {31'b0, busy}, {31'b0, ~done});
            if (done) check($sformatf("b2b_q%0d", k), {22'b0, Q_out}, 32'h180);
        end
        step();
        check("b2b_end_busy", {31'b0, busy}, 32'd0);

        // Abort with sclr sampled while cnt==5.
        A_in  = 10'h040;
        B_in  = 10'h020;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        check("abort_q", {22'b0, Q_out}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ovf", {31'b0, ovf}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("abort_novalid%0d", i), {31'b0, valid}, 32'd0);
            step();
        end
        do_op("post_abort", 10'h080, 10'h0C0, 10'h180, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
